// File: rtl/relogio_pkg.sv
// rtl/relogio_pkg.sv - shared mode type and counter sizing for the clock controller
package relogio_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HORA = 2'd1,
    SET_MIN  = 2'd2
  } modo_t;

  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/detector_botao.sv
// rtl/detector_botao.sv - button capture, press detection and optional auto-repeat
module detector_botao
  import relogio_pkg::*;
#(
  parameter bit REPEAT_EN     = 1'b0,
  parameter int REPEAT_DELAY  = 1,
  parameter int REPEAT_PERIOD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic clr,
  output logic evento
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = cnt_w(RMAX);
  localparam logic [RW-1:0] DELAY_V  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] PERIOD_V = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] FIRE_V   = RW'(1);

  logic          btn_r;
  logic          btn_d;
  logic [RW-1:0] rep_cnt;
  logic          press;
  logic          rep_fire;

  assign press    = btn_r & ~btn_d;
  // Zero means idle; a repeat fires on the cycle the count reaches one.
  assign rep_fire = REPEAT_EN && btn_r && (rep_cnt == FIRE_V);
  assign evento   = press | rep_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_r   <= 1'b0;
      btn_d   <= 1'b0;
      rep_cnt <= '0;
    end else begin
      btn_r <= btn;
      btn_d <= btn_r;
      if (!REPEAT_EN || clr || !btn_r) begin
        rep_cnt <= '0;
      end else if (press) begin
        rep_cnt <= DELAY_V;
      end else if (rep_fire) begin
        rep_cnt <= PERIOD_V;
      end else if (rep_cnt != '0) begin
        rep_cnt <= rep_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/controle_relogio.sv
// rtl/controle_relogio.sv - mode FSM, one-second prescaler and blink control for the clock
module controle_relogio
  import relogio_pkg::*;
#(
  parameter int TICK_DIV      = 50_000_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int BLINK_HALF    = 25_000_000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  btn_mode,
  input  logic  btn_inc,
  input  logic  seg_wrap,
  input  logic  min_wrap,
  output logic  seg_inc,
  output logic  min_inc,
  output logic  hora_inc,
  output logic  seg_clr,
  output modo_t modo,
  output logic  blank_hora,
  output logic  blank_min
);

  localparam int PW = cnt_w(TICK_DIV - 1);
  localparam int BW = cnt_w(BLINK_HALF - 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

  logic          mode_ev;
  logic          inc_ev;
  logic          inc_ok;
  logic          em_set;
  logic          tick;
  modo_t         modo_n;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_n;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_cnt_n;
  logic          blink;
  logic          blink_n;

  detector_botao #(
    .REPEAT_EN(1'b0)
  ) u_det_mode (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn_mode),
    .clr    (1'b0),
    .evento (mode_ev)
  );

  // A mode press also clears the increment repeat so a held button needs a fresh press.
  detector_botao #(
    .REPEAT_EN    (1'b1),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_det_inc (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn_inc),
    .clr    (mode_ev),
    .evento (inc_ev)
  );

  assign em_set = (modo == SET_HORA) || (modo == SET_MIN);
  assign inc_ok = inc_ev && !mode_ev && em_set;
  assign tick   = (modo == RUN) && (presc == PRESC_MAX);

  always_comb begin
    modo_n = modo;
    case (modo)
      RUN:      if (mode_ev) modo_n = SET_HORA;
      SET_HORA: if (mode_ev) modo_n = SET_MIN;
      SET_MIN:  if (mode_ev) modo_n = RUN;
      default:  modo_n = RUN;
    endcase
  end

  always_comb begin
    presc_n     = presc + 1'b1;
    blink_cnt_n = blink_cnt + 1'b1;
    blink_n     = blink;
    if (modo != RUN || mode_ev || tick) presc_n = '0;
    if (!em_set || mode_ev || inc_ok) begin
      blink_cnt_n = '0;
      blink_n     = 1'b0;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt_n = '0;
      blink_n     = ~blink;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      modo       <= RUN;
      presc      <= '0;
      blink_cnt  <= '0;
      blink      <= 1'b0;
      seg_inc    <= 1'b0;
      min_inc    <= 1'b0;
      hora_inc   <= 1'b0;
      seg_clr    <= 1'b0;
      blank_hora <= 1'b0;
      blank_min  <= 1'b0;
    end else begin
      modo       <= modo_n;
      presc      <= presc_n;
      blink_cnt  <= blink_cnt_n;
      blink      <= blink_n;
      seg_inc    <= tick;
      min_inc    <= (tick && seg_wrap) || (inc_ok && modo == SET_MIN);
      hora_inc   <= (tick && seg_wrap && min_wrap) || (inc_ok && modo == SET_HORA);
      seg_clr    <= mode_ev && (modo == SET_MIN);
      blank_hora <= blink_n && (modo_n == SET_HORA);
      blank_min  <= blink_n && (modo_n == SET_MIN);
    end
  end

endmodule
